// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller driving a single-port ram, push wins arbitration; RAM_FIFO_ERR_EN adds sticky overflow/underflow flags
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int N_WORDS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic pop,
  output logic pop_stall,
  output logic pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic full,
  output logic empty,
  output logic [$clog2(N_WORDS+1)-1:0] count,
  output logic ram_we,
  output logic ram_re,
  output logic [$clog2(N_WORDS)-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
`ifdef RAM_FIFO_ERR_EN
  ,
  output logic overflow,
  output logic underflow
`endif
);
  localparam int AW = $clog2(N_WORDS);
  localparam int CW = $clog2(N_WORDS+1);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_acc, pop_acc;
  always_comb begin
    full = count == CW'(N_WORDS);
    empty = count == '0;
    push_acc = !rst && push && !full;
    pop_acc = !rst && pop && !empty && !push_acc;
    pop_stall = !rst && pop && !empty && push_acc;
    ram_we = push_acc;
    ram_re = pop_acc;
    ram_address = push_acc ? wr_ptr : pop_acc ? rd_ptr : '0;
    ram_data_in = push_acc ? push_data : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      pop_valid <= 1'b0;
      pop_data <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr == AW'(N_WORDS-1) ? '0 : wr_ptr + AW'(1);
      if (pop_acc) rd_ptr <= rd_ptr == AW'(N_WORDS-1) ? '0 : rd_ptr + AW'(1);
      count <= push_acc ? count + CW'(1) : pop_acc ? count - CW'(1) : count;
      pop_valid <= pop_acc;
      if (pop_acc) pop_data <= ram_data_out;
    end
  end
`ifdef RAM_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full) overflow <= 1'b1;
      if (pop && empty) underflow <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: queue-model bench for ram_fifo_ctrl with a behavioural async-read ram
module tb_ram_fifo_ctrl;
  logic clk = 0, rst = 1, push = 0, pop = 0;
  logic [7:0] push_data = 0, pop_data, ram_data_in, ram_data_out;
  logic pop_stall, pop_valid, full, empty, ram_we, ram_re;
  logic [4:0] count;
  logic [3:0] ram_address;
`ifdef RAM_FIFO_ERR_EN
  logic overflow, underflow;
`endif
  logic [7:0] mem [16];
  int total = 0, bad = 0;
  logic chk_en = 0;
  logic [7:0] q[$];
  int n_push = 0, n_pop = 0;
  logic m_valid = 0, m_ovf = 0, m_unf = 0;
  logic [7:0] m_data = 0;
  ram_fifo_ctrl #(.DATA_WIDTH(8), .N_WORDS(16)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_stall(pop_stall), .pop_valid(pop_valid), .pop_data(pop_data),
    .full(full), .empty(empty), .count(count), .ram_we(ram_we), .ram_re(ram_re),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
`ifdef RAM_FIFO_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_we) mem[ram_address] <= ram_data_in;
  assign ram_data_out = mem[ram_address];
  function automatic logic m_pacc();
    return !rst && push && q.size() < 16;
  endfunction
  function automatic logic m_oacc();
    return !rst && pop && q.size() > 0 && !m_pacc();
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask
  task automatic tick();
    logic pa, oa;
    pa = m_pacc();
    oa = m_oacc();
    @(posedge clk);
    if (rst) begin
      q.delete();
      n_push = 0; n_pop = 0; m_valid = 0; m_data = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (push && q.size() == 16) m_ovf = 1;
      if (pop && q.size() == 0) m_unf = 1;
      if (pa) begin q.push_back(push_data); n_push++; end
      if (oa) begin m_data = q.pop_front(); n_pop++; end
      m_valid = oa;
    end
    #1;
  endtask
  task automatic step(input logic p, input logic [7:0] d, input logic o);
    push = p; push_data = d; pop = o;
    tick();
    push = 0; push_data = 0; pop = 0;
  endtask
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      logic pa, oa;
      pa = m_pacc();
      oa = m_oacc();
      chk("m_ram_we", ram_we, pa);
      chk("m_ram_re", ram_re, oa);
      chk("m_ram_address", ram_address, pa ? n_push % 16 : oa ? n_pop % 16 : 0);
      chk("m_ram_data_in", ram_data_in, pa ? push_data : 8'h00);
      chk("m_pop_stall", pop_stall, !rst && pop && q.size() > 0 && pa);
      chk("m_count", count, q.size());
      chk("m_full", full, q.size() == 16);
      chk("m_empty", empty, q.size() == 0);
      chk("m_pop_valid", pop_valid, m_valid);
      chk("m_pop_data", pop_data, m_data);
`ifdef RAM_FIFO_ERR_EN
      chk("m_overflow", overflow, m_ovf);
      chk("m_underflow", underflow, m_unf);
`endif
    end
  end
  initial begin
    logic [7:0] t1 [3];
    t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33;
    tick();
    rst = 0;
    chk_en = 1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_pop_data", pop_data, 0);
    for (int i = 0; i < 3; i++) step(1, t1[i], 0);
    chk("t1_count", count, 3);
    chk("t1_empty", empty, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      chk("t1_pop_valid", pop_valid, 1);
      chk("t1_pop_data", pop_data, t1[i]);
    end
    chk("t1_count_end", count, 0);
    chk("t1_empty_end", empty, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
    chk("t2_full", full, 1);
    step(1, 8'hFF, 0);
    chk("t2_drop_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1);
      chk("t2_pop_data", pop_data, i);
    end
    chk("t2_empty", empty, 1);
    for (int i = 0; i < 5; i++) step(1, 8'hA0 + 8'(i), 0);
    chk("t3_count5", count, 5);
    push = 1; push_data = 8'hB5; pop = 1;
    #2;
    chk("t3_ram_we", ram_we, 1);
    chk("t3_ram_re", ram_re, 0);
    chk("t3_pop_stall", pop_stall, 1);
    tick();
    push = 0; pop = 0;
    chk("t3_count6", count, 6);
    step(0, 0, 1);
    chk("t3_pop_valid", pop_valid, 1);
    chk("t3_pop_data", pop_data, 8'hA0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    chk("t3_last", pop_data, 8'hB5);
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 10; i++) step(1, 8'h40 + 8'(i), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 8'h60 + 8'(i), 0);
    push = 1; push_data = 8'h66;
    #2;
    chk("t4_wrap_addr", ram_address, 0);
    chk("t4_wrap_we", ram_we, 1);
    tick();
    push = 0;
    for (int i = 7; i < 10; i++) step(1, 8'h60 + 8'(i), 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1);
      chk("t4_pop_data", pop_data, 8'h60 + i);
    end
    for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 0);
    pop = 1; rst = 1;
    tick();
    rst = 0; pop = 0;
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_pop_valid", pop_valid, 0);
    chk("t5_pop_data", pop_data, 0);
    pop = 1;
    #2;
    chk("t5_ram_re", ram_re, 0);
    tick();
    pop = 0;
    chk("t5_pop_valid2", pop_valid, 0);
`ifdef RAM_FIFO_ERR_EN
    step(0, 0, 1);
    chk("t6_underflow", underflow, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
    step(1, 8'hEE, 0);
    chk("t6_overflow", overflow, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    chk("t6_ovf_sticky", overflow, 1);
    chk("t6_unf_sticky", underflow, 1);
    rst = 1; tick(); rst = 0;
    chk("t6_ovf_rst", overflow, 0);
    chk("t6_unf_rst", underflow, 0);
`endif
    step(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
